// File: rtl/bp_pht_update_ctrl.sv
// PHT write sequencer: post-reset/clear init sweep, then drains buffered resolved-branch
// updates one per cycle as read-modify-write saturating 2-bit counter updates.
module bp_pht_update_ctrl #(
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned Q_DEPTH  = 4,
    parameter logic [1:0]  INIT_CTR = 2'b11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_req,
    input  logic                       upd_valid,
    input  logic [IDX_W-1:0]           upd_idx,
    input  logic                       upd_taken,
    output logic                       upd_ready,
    output logic [IDX_W-1:0]           tbl_raddr,
    input  logic [1:0]                 tbl_rdata,
    output logic                       tbl_we,
    output logic [IDX_W-1:0]           tbl_waddr,
    output logic [1:0]                 tbl_wdata,
    output logic                       pred_valid,
    output logic                       init_done,
    output logic [$clog2(Q_DEPTH):0]   q_count,
    output logic [15:0]                upd_cnt
);

    localparam int unsigned PTR_W = $clog2(Q_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(Q_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    typedef enum logic {Init, Run} state_t;

    state_t           state, stateNext;
    logic [IDX_W-1:0] sweepIdx, sweepIdxNext;
    logic [PTR_W-1:0] headPtr, tailPtr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] qIdx [Q_DEPTH];
    logic             qTaken [Q_DEPTH];
    logic [15:0]      updCnt;
    logic             firstRun;
    logic             push, pop;
    logic [IDX_W-1:0] headIdx;
    logic             headTaken;

    // Encoding order is 00 < 01 < 11 < 10 (strong NT .. strong T).
    function automatic logic [1:0] nextCtr(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        unique case (ctr)
            2'b00:   res = taken ? 2'b01 : 2'b00;
            2'b01:   res = taken ? 2'b11 : 2'b00;
            2'b11:   res = taken ? 2'b10 : 2'b01;
            default: res = taken ? 2'b10 : 2'b11;
        endcase
        return res;
    endfunction

    assign headIdx    = qIdx[headPtr];
    assign headTaken  = qTaken[headPtr];
    assign pred_valid = (state == Run);
    assign init_done  = firstRun;
    assign q_count    = count;
    assign upd_cnt    = updCnt;

    always_comb begin
        stateNext    = state;
        sweepIdxNext = sweepIdx;
        push         = 1'b0;
        pop          = 1'b0;
        upd_ready    = 1'b0;
        tbl_we       = 1'b0;
        tbl_raddr    = '0;
        tbl_waddr    = '0;
        tbl_wdata    = '0;
        unique case (state)
            Init: begin
                tbl_we       = 1'b1;
                tbl_waddr    = sweepIdx;
                tbl_wdata    = INIT_CTR;
                sweepIdxNext = sweepIdx + IDX_W'(1);
                if (sweepIdx == LAST_IDX) stateNext = Run;
            end
            Run: begin
                upd_ready = (count != FULL);
                push      = upd_valid && upd_ready && !clear_req;
                pop       = (count != '0);
                if (pop) begin
                    // Combinational read; the previous cycle's write is already visible.
                    tbl_raddr = headIdx;
                    tbl_we    = 1'b1;
                    tbl_waddr = headIdx;
                    tbl_wdata = nextCtr(tbl_rdata, headTaken);
                end
            end
        endcase
        if (clear_req) begin
            stateNext    = Init;
            sweepIdxNext = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= Init;
            sweepIdx <= '0;
            headPtr  <= '0;
            tailPtr  <= '0;
            count    <= '0;
            updCnt   <= '0;
            firstRun <= 1'b0;
        end else begin
            state    <= stateNext;
            sweepIdx <= sweepIdxNext;
            firstRun <= (state == Init) && (stateNext == Run);
            if (pop) updCnt <= updCnt + 16'd1;
            if (clear_req) begin
                headPtr <= '0;
                tailPtr <= '0;
                count   <= '0;
            end else begin
                if (push) tailPtr <= tailPtr + PTR_W'(1);
                if (pop)  headPtr <= headPtr + PTR_W'(1);
                unique case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qIdx[tailPtr]   <= upd_idx;
            qTaken[tailPtr] <= upd_taken;
        end
    end

endmodule

// File: tb/tb_bp_pht_update_ctrl.sv
// Bench for bp_pht_update_ctrl: directed scenarios plus randomized traffic checked against
// a queue-based reference model; the bench also holds the PHT storage itself.
module tb_bp_pht_update_ctrl;

    localparam int N  = 64;
    localparam int QD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_req = 1'b0;
    logic       upd_valid = 1'b0;
    logic [5:0] upd_idx = '0;
    logic       upd_taken = 1'b0;
    logic       upd_ready;
    logic [5:0] tbl_raddr;
    logic [1:0] tbl_rdata;
    logic       tbl_we;
    logic [5:0] tbl_waddr;
    logic [1:0] tbl_wdata;
    logic       pred_valid;
    logic       init_done;
    logic [2:0] q_count;
    logic [15:0] upd_cnt;

    int checks = 0;
    int errors = 0;

    bp_pht_update_ctrl #(.IDX_W(6), .Q_DEPTH(QD), .INIT_CTR(2'b11)) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_ready(upd_ready), .tbl_raddr(tbl_raddr), .tbl_rdata(tbl_rdata),
        .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
        .pred_valid(pred_valid), .init_done(init_done), .q_count(q_count), .upd_cnt(upd_cnt)
    );

    always #5 clk = ~clk;

    // The pattern history table lives in the bench.
    logic [1:0] pht [N];
    assign tbl_rdata = pht[tbl_raddr];
    always @(posedge clk) if (tbl_we) pht[tbl_waddr] <= tbl_wdata;

    // Reference model state.
    typedef struct {logic [5:0] idx; logic taken;} upd_t;
    upd_t        refQ[$];
    logic [1:0]  refTable [N];
    bit          refRun = 0;
    bit          refFirst = 0;
    int          refSweep = 0;
    logic [15:0] refCnt = '0;
    bit          lastAcc = 0;

    function automatic logic [1:0] ref_next(input logic [1:0] c, input logic t);
        logic [1:0] enc [4];
        int ord;
        enc = '{2'b00, 2'b01, 2'b11, 2'b10};
        ord = 0;
        for (int k = 0; k < 4; k++) if (enc[k] == c) ord = k;
        ord = t ? ((ord < 3) ? ord + 1 : 3) : ((ord > 0) ? ord - 1 : 0);
        return enc[ord];
    endfunction

    task automatic drive(input bit r, input bit v, input int idx, input bit t, input bit clr);
        @(negedge clk);
        rst = r; upd_valid = v; upd_idx = 6'(idx); upd_taken = t; clear_req = clr;
        #1;
    endtask

    task automatic advance();
        bit acc;
        upd_t h;
        @(posedge clk);
        acc = 0;
        if (rst) begin
            refRun = 0; refSweep = 0; refQ.delete(); refCnt = '0; refFirst = 0;
        end else if (!refRun) begin
            refFirst = 0;
            if (clear_req) refSweep = 0;
            else if (refSweep == N - 1) begin
                refRun = 1; refFirst = 1;
                for (int i = 0; i < N; i++) refTable[i] = 2'b11;
            end else refSweep++;
        end else begin
            acc = upd_valid && (refQ.size() < QD) && !clear_req;
            refFirst = 0;
            if (refQ.size() > 0) begin
                h = refQ.pop_front();
                refTable[h.idx] = ref_next(refTable[h.idx], h.taken);
                refCnt++;
            end
            if (acc) refQ.push_back('{idx: upd_idx, taken: upd_taken});
            if (clear_req) begin refQ.delete(); refRun = 0; refSweep = 0; end
        end
        lastAcc = acc;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0); advance();
        drive(1, 0, 0, 0, 0); advance();
        checks++;
        if ({pred_valid, init_done, upd_ready} !== 3'b000 || q_count !== 3'd0 || upd_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: pv/id/rdy=%b%b%b q=%0d cnt=%0d required 000 q=0 cnt=0",
                     pred_valid, init_done, upd_ready, q_count, upd_cnt);
        end
        for (int i = 0; i < N; i++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (tbl_we !== 1'b1 || tbl_waddr !== 6'(i) || tbl_wdata !== 2'b11 ||
                pred_valid !== 1'b0 || upd_ready !== 1'b0 || init_done !== 1'b0) begin
                errors++;
                $display("FAIL sweep[%0d]: we=%b waddr=%0d wdata=%b pv=%b rdy=%b id=%b required 1 %0d 11 0 0 0",
                         i, tbl_we, tbl_waddr, tbl_wdata, pred_valid, upd_ready, init_done, i);
            end
            advance();
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({pred_valid, init_done, upd_ready, tbl_we} !== 4'b1110) begin
            errors++;
            $display("FAIL first_run: pv/id/rdy/we=%b%b%b%b required 1110",
                     pred_valid, init_done, upd_ready, tbl_we);
        end
        advance();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (init_done !== 1'b0 || pred_valid !== 1'b1) begin
            errors++;
            $display("FAIL init_done_pulse: id=%b pv=%b required 0 1", init_done, pred_valid);
        end
        advance();
    endtask

    task automatic test_taken_seq();
        logic [1:0] exp [3];
        exp = '{2'b10, 2'b10, 2'b10};
        drive(0, 1, 5, 1, 0);
        checks++;
        if (tbl_we !== 1'b0) begin
            errors++; $display("FAIL taken_idle_we: got %b required 0", tbl_we);
        end
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(0, k < 2, 5, 1, 0);
            checks++;
            if (tbl_we !== 1'b1 || tbl_waddr !== 6'd5 || tbl_wdata !== exp[k]) begin
                errors++;
                $display("FAIL taken_write[%0d]: we=%b waddr=%0d wdata=%b required 1 5 %b",
                         k, tbl_we, tbl_waddr, tbl_wdata, exp[k]);
            end
            advance();
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (upd_cnt !== 16'd3 || q_count !== 3'd0 || tbl_we !== 1'b0) begin
            errors++;
            $display("FAIL taken_count: cnt=%0d q=%0d we=%b required 3 0 0", upd_cnt, q_count, tbl_we);
        end
        advance();
    endtask

    task automatic test_not_taken_seq();
        logic [1:0] exp [4];
        logic       tk  [4];
        exp = '{2'b01, 2'b00, 2'b00, 2'b01};
        tk  = '{1'b0, 1'b0, 1'b0, 1'b1};
        drive(0, 1, 9, tk[0], 0); advance();
        for (int k = 0; k < 4; k++) begin
            drive(0, k < 3, 9, (k < 3) ? tk[k + 1] : 1'b0, 0);
            checks++;
            if (tbl_we !== 1'b1 || tbl_waddr !== 6'd9 || tbl_wdata !== exp[k]) begin
                errors++;
                $display("FAIL nt_write[%0d]: we=%b waddr=%0d wdata=%b required 1 9 %b",
                         k, tbl_we, tbl_waddr, tbl_wdata, exp[k]);
            end
            advance();
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (upd_cnt !== 16'd7) begin
            errors++; $display("FAIL nt_count: got %0d required 7", upd_cnt);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [15:0] startCnt;
        int accepted;
        startCnt = refCnt;
        accepted = 0;
        for (int k = 0; k < 12; k++) begin
            drive(0, 1, $urandom_range(N - 1), $urandom_range(1), 0);
            checks++;
            if (q_count > 3'd4 || upd_ready !== (q_count != 3'd4) || q_count !== 3'(refQ.size())) begin
                errors++;
                $display("FAIL b2b_occupancy[%0d]: q=%0d rdy=%b required q=%0d rdy=%b",
                         k, q_count, upd_ready, refQ.size(), refQ.size() != QD);
            end
            checks++;
            if (refQ.size() > 0 && (tbl_we !== 1'b1 || tbl_waddr !== refQ[0].idx ||
                tbl_wdata !== ref_next(refTable[refQ[0].idx], refQ[0].taken))) begin
                errors++;
                $display("FAIL b2b_write[%0d]: we=%b waddr=%0d wdata=%b required 1 %0d %b", k,
                         tbl_we, tbl_waddr, tbl_wdata, refQ[0].idx,
                         ref_next(refTable[refQ[0].idx], refQ[0].taken));
            end
            advance();
            accepted += int'(lastAcc);
        end
        for (int k = 0; k < QD + 1; k++) begin drive(0, 0, 0, 0, 0); advance(); end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (upd_cnt !== startCnt + 16'(accepted) || accepted != 12) begin
            errors++;
            $display("FAIL b2b_count: cnt=%0d accepted=%0d required cnt=%0d accepted=12",
                     upd_cnt, accepted, startCnt + 16'(accepted));
        end
        advance();
    endtask

    task automatic test_clear();
        drive(0, 1, 20, 1, 0); advance();
        drive(0, 1, 33, 0, 1);
        checks++;
        if (tbl_we !== 1'b1 || tbl_waddr !== 6'd20 || q_count !== 3'd1) begin
            errors++;
            $display("FAIL clear_head_write: we=%b waddr=%0d q=%0d required 1 20 1",
                     tbl_we, tbl_waddr, q_count);
        end
        advance();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (pred_valid !== 1'b0 || q_count !== 3'd0 || tbl_we !== 1'b1 || tbl_waddr !== 6'd0 ||
            upd_ready !== 1'b0 || upd_cnt !== refCnt) begin
            errors++;
            $display("FAIL clear_restart: pv=%b q=%0d we=%b waddr=%0d rdy=%b cnt=%0d required 0 0 1 0 0 %0d",
                     pred_valid, q_count, tbl_we, tbl_waddr, upd_ready, upd_cnt, refCnt);
        end
        advance();
        for (int i = 1; i < N; i++) begin drive(0, 0, 0, 0, 0); advance(); end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (tbl_we !== 1'b0 || pred_valid !== 1'b1) begin
                errors++;
                $display("FAIL clear_dropped[%0d]: we=%b pv=%b required 0 1", k, tbl_we, pred_valid);
            end
            advance();
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (pht[33] !== 2'b11) begin
            errors++; $display("FAIL clear_entry33: got %b required 11", pht[33]);
        end
        advance();
    endtask

    task automatic test_random();
        int k;
        for (int c = 0; c < 400; c++) begin
            drive(0, $urandom_range(1), $urandom_range(N - 1), $urandom_range(1),
                  $urandom_range(63) == 0);
            checks++;
            if (tbl_we !== (!refRun || refQ.size() > 0)) begin
                errors++; $display("FAIL rnd_we[%0d]: got %b required %b", c, tbl_we,
                                   !refRun || refQ.size() > 0);
            end else if (!refRun) begin
                checks++;
                if (tbl_waddr !== 6'(refSweep) || tbl_wdata !== 2'b11) begin
                    errors++; $display("FAIL rnd_sweep[%0d]: waddr=%0d wdata=%b required %0d 11",
                                       c, tbl_waddr, tbl_wdata, refSweep);
                end
            end else if (refQ.size() > 0) begin
                checks++;
                if (tbl_waddr !== refQ[0].idx || tbl_raddr !== refQ[0].idx ||
                    tbl_wdata !== ref_next(refTable[refQ[0].idx], refQ[0].taken)) begin
                    errors++;
                    $display("FAIL rnd_write[%0d]: waddr=%0d raddr=%0d wdata=%b required %0d %0d %b",
                             c, tbl_waddr, tbl_raddr, tbl_wdata, refQ[0].idx, refQ[0].idx,
                             ref_next(refTable[refQ[0].idx], refQ[0].taken));
                end
            end
            checks++;
            if (pred_valid !== refRun || init_done !== refFirst ||
                upd_ready !== (refRun && refQ.size() != QD) || q_count !== 3'(refQ.size()) ||
                upd_cnt !== refCnt) begin
                errors++;
                $display("FAIL rnd_status[%0d]: pv=%b id=%b rdy=%b q=%0d cnt=%0d required %b %b %b %0d %0d",
                         c, pred_valid, init_done, upd_ready, q_count, upd_cnt, refRun, refFirst,
                         refRun && refQ.size() != QD, refQ.size(), refCnt);
            end
            advance();
        end
        k = 0;
        while (!(refRun && refQ.size() == 0) && k < 200) begin
            drive(0, 0, 0, 0, 0); advance(); k++;
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (k >= 200) begin
            errors++; $display("FAIL rnd_drain: model did not reach idle RUN within 200 cycles");
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pht[i] !== refTable[i]) begin
                    errors++;
                    $display("FAIL rnd_table[%0d]: got %b required %b", i, pht[i], refTable[i]);
                end
            end
        end
        advance();
    endtask

    task automatic test_rst_mid_sweep();
        drive(0, 0, 0, 0, 1); advance();
        for (int i = 0; i < 40; i++) begin drive(0, 0, 0, 0, 0); advance(); end
        drive(1, 0, 0, 0, 0);
        checks++;
        if (tbl_waddr !== 6'd40 || tbl_we !== 1'b1) begin
            errors++; $display("FAIL rst_at_40: waddr=%0d we=%b required 40 1", tbl_waddr, tbl_we);
        end
        advance();
        for (int i = 0; i < N; i++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (pred_valid !== 1'b0 || tbl_waddr !== 6'(i) || tbl_we !== 1'b1) begin
                errors++;
                $display("FAIL rst_resweep[%0d]: pv=%b waddr=%0d we=%b required 0 %0d 1",
                         i, pred_valid, tbl_waddr, tbl_we, i);
            end
            advance();
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (pred_valid !== 1'b1 || init_done !== 1'b1 || upd_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_rerun: pv=%b id=%b cnt=%0d required 1 1 0", pred_valid, init_done, upd_cnt);
        end
        advance();
    endtask

    initial begin
        test_reset();
        test_taken_seq();
        test_not_taken_seq();
        test_back_to_back();
        test_clear();
        test_random();
        test_rst_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
